// File: rtl/mem_bus_arbiter_if.sv
// Signal bundle between the Dcache/Icache controllers, memory and mem_bus_arbiter.
// Defining MEM_ARB_STATS_EN adds the grant/reject statistic outputs.
interface mem_bus_arbiter_if;
  logic [1:0]  d2arb_command;
  logic [63:0] d2arb_addr;
  logic [63:0] d2arb_data;
  logic [1:0]  i2arb_command;
  logic [63:0] i2arb_addr;
  logic        dcache_flush;
  logic [1:0]  proc2mem_command;
  logic [63:0] proc2mem_addr;
  logic [63:0] proc2mem_data;
  logic [3:0]  mem2proc_response;
  logic [63:0] mem2proc_data;
  logic [3:0]  mem2proc_tag;
  logic [3:0]  arb2d_response;
  logic [3:0]  arb2d_tag;
  logic [3:0]  arb2i_response;
  logic [3:0]  arb2i_tag;
  logic [63:0] arb2mem_data;
  logic        tag_err;
`ifdef MEM_ARB_STATS_EN
  logic [31:0] stat_d_grants;
  logic [31:0] stat_i_grants;
  logic [31:0] stat_rejects;

  modport master (
    input  d2arb_command, d2arb_addr, d2arb_data, i2arb_command, i2arb_addr,
           dcache_flush, mem2proc_response, mem2proc_data, mem2proc_tag,
    output proc2mem_command, proc2mem_addr, proc2mem_data, arb2d_response, arb2d_tag,
           arb2i_response, arb2i_tag, arb2mem_data, tag_err,
           stat_d_grants, stat_i_grants, stat_rejects
  );
  modport slave (
    output d2arb_command, d2arb_addr, d2arb_data, i2arb_command, i2arb_addr,
           dcache_flush, mem2proc_response, mem2proc_data, mem2proc_tag,
    input  proc2mem_command, proc2mem_addr, proc2mem_data, arb2d_response, arb2d_tag,
           arb2i_response, arb2i_tag, arb2mem_data, tag_err,
           stat_d_grants, stat_i_grants, stat_rejects
  );
`else
  modport master (
    input  d2arb_command, d2arb_addr, d2arb_data, i2arb_command, i2arb_addr,
           dcache_flush, mem2proc_response, mem2proc_data, mem2proc_tag,
    output proc2mem_command, proc2mem_addr, proc2mem_data, arb2d_response, arb2d_tag,
           arb2i_response, arb2i_tag, arb2mem_data, tag_err
  );
  modport slave (
    output d2arb_command, d2arb_addr, d2arb_data, i2arb_command, i2arb_addr,
           dcache_flush, mem2proc_response, mem2proc_data, mem2proc_tag,
    input  proc2mem_command, proc2mem_addr, proc2mem_data, arb2d_response, arb2d_tag,
           arb2i_response, arb2i_tag, arb2mem_data, tag_err
  );
`endif
endinterface

// File: rtl/mem_bus_arbiter.sv
// Dcache/Icache memory bus arbiter with tag-ownership routing and Icache starvation guard.
// Optional statistics counters are enabled by defining MEM_ARB_STATS_EN.
module mem_bus_arbiter #(
  parameter int NUM_TAGS     = 16,
  parameter int STARVE_LIMIT = 8
) (
  input logic               clock,
  input logic               reset,
  mem_bus_arbiter_if.master bus
);
  localparam logic [1:0] BUS_NONE = 2'd0;
  localparam logic [1:0] BUS_LOAD = 2'd1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  logic [NUM_TAGS-1:0] tab_valid;
  logic [NUM_TAGS-1:0] tab_owner;  // 0 = Dcache, 1 = Icache
  logic [SW-1:0]       starve_cnt;
  logic                err_sticky;

  logic d_req, i_req, i_win, d_win, accepted, alloc, ret_hit, ret_miss;

  assign d_req    = bus.d2arb_command != BUS_NONE;
  assign i_req    = bus.i2arb_command == BUS_LOAD;
  // Flush locks the Icache out entirely, even when the Dcache is idle.
  assign i_win    = i_req && !bus.dcache_flush && (!d_req || starve_cnt == STARVE_MAX);
  assign d_win    = d_req && !i_win;
  assign accepted = bus.mem2proc_response != 4'd0;
  assign alloc    = accepted && (i_win || (d_win && bus.d2arb_command == BUS_LOAD));
  assign ret_hit  = (bus.mem2proc_tag != 4'd0) && tab_valid[bus.mem2proc_tag];
  assign ret_miss = (bus.mem2proc_tag != 4'd0) && !tab_valid[bus.mem2proc_tag];

  assign bus.proc2mem_command = d_win ? bus.d2arb_command : (i_win ? bus.i2arb_command : BUS_NONE);
  assign bus.proc2mem_addr    = d_win ? bus.d2arb_addr : (i_win ? bus.i2arb_addr : 64'd0);
  assign bus.proc2mem_data    = d_win ? bus.d2arb_data : 64'd0;
  assign bus.arb2d_response   = d_win ? bus.mem2proc_response : 4'd0;
  assign bus.arb2i_response   = i_win ? bus.mem2proc_response : 4'd0;
  assign bus.arb2d_tag        = (ret_hit && !tab_owner[bus.mem2proc_tag]) ? bus.mem2proc_tag : 4'd0;
  assign bus.arb2i_tag        = (ret_hit &&  tab_owner[bus.mem2proc_tag]) ? bus.mem2proc_tag : 4'd0;
  assign bus.arb2mem_data     = bus.mem2proc_data;
  assign bus.tag_err          = err_sticky;

  // Return clears before allocation sets, so a same-tag allocation wins the write.
  always_ff @(posedge clock) begin
    if (reset) begin
      tab_valid  <= '0;
      starve_cnt <= '0;
      err_sticky <= 1'b0;
    end else begin
      if (ret_hit)  tab_valid[bus.mem2proc_tag] <= 1'b0;
      if (ret_miss) err_sticky <= 1'b1;
      if (alloc)    tab_valid[bus.mem2proc_response] <= 1'b1;
      if (i_req && !i_win)
        starve_cnt <= (starve_cnt == STARVE_MAX) ? STARVE_MAX : starve_cnt + 1'b1;
      else
        starve_cnt <= '0;
    end
  end

  always_ff @(posedge clock) begin
    if (alloc) tab_owner[bus.mem2proc_response] <= i_win;
  end

`ifdef MEM_ARB_STATS_EN
  logic [31:0] d_grants, i_grants, rejects;

  always_ff @(posedge clock) begin
    if (reset) begin
      d_grants <= '0;
      i_grants <= '0;
      rejects  <= '0;
    end else begin
      if (d_win && accepted && d_grants != '1)            d_grants <= d_grants + 32'd1;
      if (i_win && accepted && i_grants != '1)            i_grants <= i_grants + 32'd1;
      if ((d_win || i_win) && !accepted && rejects != '1) rejects  <= rejects + 32'd1;
    end
  end

  assign bus.stat_d_grants = d_grants;
  assign bus.stat_i_grants = i_grants;
  assign bus.stat_rejects  = rejects;
`endif
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: driver predicts from a tag-owner map, monitor compares.
module tb_mem_bus_arbiter;
  localparam int STARVE_LIMIT = 8;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  mem_bus_arbiter_if bus();

  mem_bus_arbiter #(.NUM_TAGS(16), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [1:0]  cmd;
    logic [63:0] addr;
    logic [63:0] data;
    logic [3:0]  d_resp;
    logic [3:0]  i_resp;
    logic [3:0]  d_tag;
    logic [3:0]  i_tag;
    logic [63:0] mdata;
    logic        err;
    int          step;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   step_no  = 0;

  // Reference state: which requester owns each outstanding tag, consecutive Icache denials.
  int owner_of[int];
  int i_denied  = 0;
  bit err_model = 1'b0;
  int last_win  = 0;  // 0 none, 1 Dcache, 2 Icache

  task automatic chk(input string name, input int step, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s (step %0d): actual 0x%0h required 0x%0h", name, step, act, req);
  endtask

  always @(negedge clock) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      chk("proc2mem_command", mon_e.step, 64'(bus.proc2mem_command), 64'(mon_e.cmd));
      chk("proc2mem_addr",    mon_e.step, bus.proc2mem_addr, mon_e.addr);
      chk("proc2mem_data",    mon_e.step, bus.proc2mem_data, mon_e.data);
      chk("arb2d_response",   mon_e.step, 64'(bus.arb2d_response), 64'(mon_e.d_resp));
      chk("arb2i_response",   mon_e.step, 64'(bus.arb2i_response), 64'(mon_e.i_resp));
      chk("arb2d_tag",        mon_e.step, 64'(bus.arb2d_tag), 64'(mon_e.d_tag));
      chk("arb2i_tag",        mon_e.step, 64'(bus.arb2i_tag), 64'(mon_e.i_tag));
      chk("arb2mem_data",     mon_e.step, bus.arb2mem_data, mon_e.mdata);
      chk("tag_err",          mon_e.step, 64'(bus.tag_err), 64'(mon_e.err));
    end
  end

  task automatic set_idle();
    bus.d2arb_command     = 2'd0;
    bus.d2arb_addr        = 64'd0;
    bus.d2arb_data        = 64'd0;
    bus.i2arb_command     = 2'd0;
    bus.i2arb_addr        = 64'd0;
    bus.dcache_flush      = 1'b0;
    bus.mem2proc_response = 4'd0;
    bus.mem2proc_data     = 64'd0;
    bus.mem2proc_tag      = 4'd0;
  endtask

  task automatic do_reset(input int cycles);
    @(posedge clock); #1;
    reset = 1'b1;
    set_idle();
    repeat (cycles) @(posedge clock);
    #1;
    reset = 1'b0;
    owner_of.delete();
    i_denied  = 0;
    err_model = 1'b0;
  endtask

  // One bus cycle: drive inputs, predict outputs, then advance the reference state.
  task automatic cycle(input logic [1:0] dc, input logic [63:0] da, input logic [63:0] dd,
                       input logic [1:0] ic, input logic [63:0] ia, input logic fl,
                       input logic [3:0] resp, input logic [3:0] rtag, input logic [63:0] rdata);
    exp_t e;
    int   win;
    @(posedge clock); #1;
    step_no++;
    bus.d2arb_command     = dc;
    bus.d2arb_addr        = da;
    bus.d2arb_data        = dd;
    bus.i2arb_command     = ic;
    bus.i2arb_addr        = ia;
    bus.dcache_flush      = fl;
    bus.mem2proc_response = resp;
    bus.mem2proc_tag      = rtag;
    bus.mem2proc_data     = rdata;

    if (ic != 2'd0 && !fl && (dc == 2'd0 || i_denied >= STARVE_LIMIT)) win = 2;
    else if (dc != 2'd0) win = 1;
    else win = 0;
    last_win = win;

    e.cmd    = (win == 1) ? dc : (win == 2) ? ic : 2'd0;
    e.addr   = (win == 1) ? da : (win == 2) ? ia : 64'd0;
    e.data   = (win == 1) ? dd : 64'd0;
    e.d_resp = (win == 1) ? resp : 4'd0;
    e.i_resp = (win == 2) ? resp : 4'd0;
    e.d_tag  = 4'd0;
    e.i_tag  = 4'd0;
    if (rtag != 4'd0 && owner_of.exists(int'(rtag))) begin
      if (owner_of[int'(rtag)] == 0) e.d_tag = rtag;
      else                           e.i_tag = rtag;
    end
    e.mdata = rdata;
    e.err   = err_model;
    e.step  = step_no;
    exp_q.push_back(e);

    if (rtag != 4'd0) begin
      if (owner_of.exists(int'(rtag))) owner_of.delete(int'(rtag));
      else err_model = 1'b1;
    end
    if (resp != 4'd0 && ((win == 1 && dc == 2'd1) || win == 2))
      owner_of[int'(resp)] = (win == 2) ? 1 : 0;
    if (ic != 2'd0 && win != 2) i_denied = (i_denied + 1 > STARVE_LIMIT) ? STARVE_LIMIT : i_denied + 1;
    else i_denied = 0;
  endtask

  task automatic idle_ret(input logic [3:0] rtag);
    cycle(2'd0, 64'd0, 64'd0, 2'd0, 64'd0, 1'b0, 4'd0, rtag, 64'hDEAD_0000 + 64'(rtag));
  endtask

  task automatic random_phase(input int n_cycles);
    int         keys[$];
    int         r;
    logic [3:0] rt, rs;
    logic [1:0] dc, ic;
    logic       fl;
    fl = 1'b0;
    for (int n = 0; n < n_cycles; n++) begin
      keys.delete();
      foreach (owner_of[k]) keys.push_back(k);
      r = int'($urandom_range(0, 9));
      if (r < 5) rt = 4'd0;
      else if (r < 9 && keys.size() > 0) rt = 4'(keys[$urandom_range(0, keys.size() - 1)]);
      else rt = 4'($urandom_range(1, 15));
      rs = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      dc = ($urandom_range(0, 6) == 0) ? 2'd0 : 2'($urandom_range(1, 2));
      ic = ($urandom_range(0, 4) == 0) ? 2'd0 : 2'd1;
      if ($urandom_range(0, 19) == 0) fl = ~fl;
      if ($urandom_range(0, 199) == 0) do_reset(1);
      cycle(dc, {$urandom, $urandom}, {$urandom, $urandom}, ic, {$urandom, $urandom}, fl,
            rs, rt, {$urandom, $urandom});
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, actual running required finished");
    $fatal(1, "timeout");
  end

  initial begin
    set_idle();
    do_reset(2);
    idle_ret(4'd0);

    // Dcache beats Icache; accepted tag routed back to the Dcache only.
    cycle(2'd1, 64'h100, 64'd0, 2'd1, 64'h200, 1'b0, 4'd3, 4'd0, 64'd0);
    @(negedge clock); #1;
    chk("tp1_addr", step_no, bus.proc2mem_addr, 64'h100);
    chk("tp1_d_resp", step_no, 64'(bus.arb2d_response), 64'd3);
    chk("tp1_i_resp", step_no, 64'(bus.arb2i_response), 64'd0);
    idle_ret(4'd3);
    @(negedge clock); #1;
    chk("tp1_d_tag", step_no, 64'(bus.arb2d_tag), 64'd3);
    chk("tp1_i_tag", step_no, 64'(bus.arb2i_tag), 64'd0);

    // Continuous Dcache traffic: Icache must win on cycle STARVE_LIMIT+1 only.
    for (int k = 1; k <= 10; k++) begin
      cycle(2'd2, 64'h1000 + 64'(k), 64'(k), 2'd1, 64'h2000, 1'b0, 4'd1, 4'd0, 64'd0);
      @(negedge clock); #1;
      chk("starve_addr", step_no, bus.proc2mem_addr, (k == STARVE_LIMIT + 1) ? 64'h2000 : 64'h1000 + 64'(k));
    end
    idle_ret(4'd1);

    // Flush blocks the Icache for 20 cycles; it wins at once when flush drops.
    for (int k = 0; k < 20; k++) begin
      cycle(2'd2, 64'h3000, 64'h55, 2'd1, 64'h4000, 1'b1, 4'd2, 4'd0, 64'd0);
      @(negedge clock); #1;
      chk("flush_i_resp", step_no, 64'(bus.arb2i_response), 64'd0);
    end
    cycle(2'd2, 64'h3000, 64'h55, 2'd1, 64'h4000, 1'b0, 4'd2, 4'd0, 64'd0);
    @(negedge clock); #1;
    chk("flush_release_i_resp", step_no, 64'(bus.arb2i_response), 64'd2);
    idle_ret(4'd2);

    // Accepted store allocates nothing: its tag returning is an error.
    cycle(2'd2, 64'h500, 64'hABCD, 2'd0, 64'd0, 1'b0, 4'd5, 4'd0, 64'd0);
    idle_ret(4'd5);
    @(negedge clock); #1;
    chk("store_ret_d_tag", step_no, 64'(bus.arb2d_tag), 64'd0);
    chk("store_ret_i_tag", step_no, 64'(bus.arb2i_tag), 64'd0);
    idle_ret(4'd0);
    @(negedge clock); #1;
    chk("store_tag_err", step_no, 64'(bus.tag_err), 64'd1);

    // Allocate tag 2 for Icache while Dcache tag 7 returns.
    cycle(2'd1, 64'h700, 64'd0, 2'd0, 64'd0, 1'b0, 4'd7, 4'd0, 64'd0);
    cycle(2'd0, 64'd0, 64'd0, 2'd1, 64'h880, 1'b0, 4'd2, 4'd7, 64'h77);
    @(negedge clock); #1;
    chk("simul_d_tag", step_no, 64'(bus.arb2d_tag), 64'd7);
    idle_ret(4'd2);
    @(negedge clock); #1;
    chk("simul_i_tag", step_no, 64'(bus.arb2i_tag), 64'd2);

    // Same tag returns and reallocates: old owner sees the return, new owner keeps it.
    cycle(2'd1, 64'h900, 64'd0, 2'd0, 64'd0, 1'b0, 4'd9, 4'd0, 64'd0);
    cycle(2'd0, 64'd0, 64'd0, 2'd1, 64'h990, 1'b0, 4'd9, 4'd9, 64'h99);
    idle_ret(4'd9);
    @(negedge clock); #1;
    chk("same_tag_i_tag", step_no, 64'(bus.arb2i_tag), 64'd9);

    // Reset with tag 4 outstanding drops it.
    cycle(2'd1, 64'h400, 64'd0, 2'd0, 64'd0, 1'b0, 4'd4, 4'd0, 64'd0);
    do_reset(1);
    idle_ret(4'd4);
    @(negedge clock); #1;
    chk("rst_ret_d_tag", step_no, 64'(bus.arb2d_tag), 64'd0);
    chk("rst_ret_i_tag", step_no, 64'(bus.arb2i_tag), 64'd0);
    idle_ret(4'd0);
    @(negedge clock); #1;
    chk("rst_tag_err", step_no, 64'(bus.tag_err), 64'd1);

    random_phase(700);

    @(negedge clock); #1;
    chk("scoreboard_drained", step_no, 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Sits directly downstream of the Dcache controller's proc2mem/mem2proc port and the Icache controller's memory port; drives the single memory bus.
- Each cycle it picks one requester and passes its command, address and data to memory. It returns the accepted response tag to the winner only.
- A tag-ownership table routes later mem2proc_tag/data returns to the requester that issued the load.
- A starvation counter stops the Dcache from locking out instruction fetch indefinitely.

Parameters:
- NUM_TAGS, 16, tag-table depth; tag 0 is reserved and means "none".
- STARVE_LIMIT, 8, consecutive Icache-denied cycles after which the Icache wins arbitration for one cycle.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- d2arb_command  in  2  Dcache command (BUS_NONE=0, BUS_LOAD=1, BUS_STORE=2)
- d2arb_addr  in  64  Dcache address
- d2arb_data  in  64  Dcache store data
- i2arb_command  in  2  Icache command (BUS_LOAD or BUS_NONE only)
- i2arb_addr  in  64  Icache address
- dcache_flush  in  1  Dcache controller is in write_back_stage; Icache is blocked
- proc2mem_command  out  2  command to memory
- proc2mem_addr  out  64  address to memory
- proc2mem_data  out  64  data to memory
- mem2proc_response  in  4  memory accept tag; 0 = rejected
- mem2proc_data  in  64  returned load data
- mem2proc_tag  in  4  returning tag; 0 = no return
- arb2d_response  out  4  accept tag for Dcache; 0 unless Dcache won
- arb2d_tag  out  4  return tag for Dcache; 0 unless the tag is owned by Dcache
- arb2i_response  out  4  accept tag for Icache
- arb2i_tag  out  4  return tag for Icache
- arb2mem_data  out  64  mem2proc_data broadcast to both requesters
- tag_err  out  1  sticky flag: a return arrived for an unowned tag

Behaviour:
- Reset:
  - All table entries invalid.
  - Starve counter = 0; tag_err = 0.
  - All outputs are combinationally 0 while no request is active.
- Arbitration (combinational, same cycle):
  - Default priority: Dcache wins whenever d2arb_command != BUS_NONE.
  - Icache wins if the Dcache is idle, or if starve_cnt == STARVE_LIMIT and dcache_flush = 0.
  - While dcache_flush = 1, the Icache never wins.
  - Winner's command, address and data drive proc2mem_*. proc2mem_data = 0 when the Icache wins.
  - No winner: proc2mem_command = BUS_NONE, proc2mem_addr = 0.
- Response:
  - mem2proc_response goes to the winner's *_response output only; the loser sees 0.
  - A requester retries on response 0; the arbiter holds no request state.
- Allocation: on a clock edge where the winner issued BUS_LOAD and mem2proc_response != 0:
  - table[response].valid <= 1.
  - table[response].owner <= 0 for Dcache, 1 for Icache.
  - An accepted BUS_STORE allocates nothing.
- Return:
  - When mem2proc_tag != 0 and table[tag].valid, the tag goes combinationally to the owner's *_tag output only.
  - The entry is cleared at the edge.
  - When mem2proc_tag != 0 and the entry is invalid, both *_tag outputs are 0 and tag_err <= 1. tag_err is cleared only by reset.
- Simultaneous events:
  - Allocating tag A while tag B returns in the same cycle: both take effect.
  - A == B: the return is processed against the old entry contents and the allocation wins the write.
- Starve counter:
  - Increments (saturating at STARVE_LIMIT) when the Icache requests and loses.
  - Clears to 0 when the Icache wins or is not requesting.
- Reset mid-operation clears the table. Returns for tags already in flight then set tag_err and are dropped.

Optional Feature:
- Macro: MEM_ARB_STATS_EN.
- When defined, adds outputs stat_d_grants, stat_i_grants and stat_rejects (32 bits each, saturating, reset to 0).
  - stat_d_grants / stat_i_grants count accepted requests per requester.
  - stat_rejects counts winner cycles with mem2proc_response = 0.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Dcache BUS_LOAD at 0x100 with Icache BUS_LOAD at 0x200, response = 3:
  - proc2mem_addr = 0x100; arb2d_response = 3; arb2i_response = 0.
  - Later mem2proc_tag = 3 gives arb2d_tag = 3 and arb2i_tag = 0.
- Dcache requests continuously and the Icache waits with responses accepted:
  - The Icache wins on the 9th cycle (STARVE_LIMIT = 8), then the counter is 0.
- Same continuous-request stimulus with dcache_flush = 1:
  - The Icache never wins over 20 cycles; the counter saturates at 8.
- Dcache BUS_STORE accepted with response 5, then mem2proc_tag = 5:
  - Both *_tag outputs are 0 and tag_err = 1.
- Icache load is accepted with tag 2 while tag 7 (Dcache-owned) returns in the same cycle:
  - arb2d_tag = 7.
  - Next cycle mem2proc_tag = 2 gives arb2i_tag = 2.
- Assert reset with tag 4 outstanding:
  - The table clears; a subsequent mem2proc_tag = 4 sets tag_err = 1 and both *_tag outputs are 0.
